// File: rtl/lsu_mem_master_if.sv
// Load/store request, response and word-memory signals shared by the LSU and its environment.
// The master modport is the LSU side; the slave modport is the core/memory side.
interface lsu_mem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_data_out;
   logic [31:0] mem_data_in;
   logic        mem_we;

   modport master (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, mem_data_in,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data_out, mem_we
   );

   modport slave (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, mem_data_in,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data_out, mem_we
   );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator for a single-port word memory; sub-word stores are read-modify-write.
// Latency accept->rsp_valid: load/SW 2, SB/SH 3, error 1; one request at a time, response held until rsp_ready.
module lsu_mem_master #(
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic              clk,
   input  logic              resetn,
   lsu_mem_master_if.master  bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state, state_nxt;
   logic [31:0] addr_q, wdata_q, word_q, rdata_q;
   logic [2:0]  f3_q;
   logic        store_q, err_q;
   logic        req_err;
   logic [31:0] shifted, load_val, merge_val;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      req_err = 1'b0;
      case (bus.req_funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_err = 1'b0;
         default:                                req_err = 1'b1;
      endcase
      if (bus.req_store && bus.req_funct3[2])                          req_err = 1'b1;
      if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])             req_err = 1'b1;
      if (bus.req_funct3 == 3'b010 && bus.req_addr[1:0] != 2'b00)      req_err = 1'b1;
      if (bus.req_addr >= MEM_BYTES)                                   req_err = 1'b1;
   end

   always_comb begin
      shifted = bus.mem_data_in >> {addr_q[1:0], 3'b000};
      lane_b  = shifted[7:0];
      lane_h  = addr_q[1] ? bus.mem_data_in[31:16] : bus.mem_data_in[15:0];
      case (f3_q)
         3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_val = {24'd0, lane_b};
         3'b101:  load_val = {16'd0, lane_h};
         default: load_val = bus.mem_data_in;
      endcase
   end

   // Sub-word stores overwrite one lane of the word captured during READ.
   always_comb begin
      merge_val = word_q;
      if (f3_q[1:0] == 2'b00) begin
         case (addr_q[1:0])
            2'b00:   merge_val[7:0]   = wdata_q[7:0];
            2'b01:   merge_val[15:8]  = wdata_q[7:0];
            2'b10:   merge_val[23:16] = wdata_q[7:0];
            default: merge_val[31:24] = wdata_q[7:0];
         endcase
      end else if (f3_q[1:0] == 2'b01) begin
         if (addr_q[1]) merge_val[31:16] = wdata_q[15:0];
         else           merge_val[15:0]  = wdata_q[15:0];
      end else begin
         merge_val = wdata_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.req_valid) begin
            if (req_err)                                          state_nxt = RESP;
            else if (bus.req_store && bus.req_funct3 == 3'b010)   state_nxt = WRITE;
            else                                                  state_nxt = READ;
         end
         READ:    state_nxt = store_q ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         default: if (bus.rsp_ready) state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready    = 1'b0;
      bus.rsp_valid    = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_address  = 32'd0;
      bus.mem_data_out = 32'd0;
      case (state)
         IDLE:  bus.req_ready = 1'b1;
         READ:  bus.mem_address = {addr_q[31:2], 2'b00};
         WRITE: begin
            bus.mem_we       = 1'b1;
            bus.mem_address  = {addr_q[31:2], 2'b00};
            bus.mem_data_out = merge_val;
         end
         default: bus.rsp_valid = 1'b1;
      endcase
   end

   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         word_q  <= 32'd0;
         rdata_q <= 32'd0;
         f3_q    <= 3'd0;
         store_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               addr_q  <= bus.req_addr;
               wdata_q <= bus.req_wdata;
               f3_q    <= bus.req_funct3;
               store_q <= bus.req_store;
               err_q   <= req_err;
               if (req_err) rdata_q <= 32'd0;
            end
            READ: begin
               word_q <= bus.mem_data_in;
               if (!store_q) rdata_q <= load_val;
            end
            WRITE:   rdata_q <= 32'd0;
            default: if (bus.rsp_ready) err_q <= 1'b0;
         endcase
      end
   end

endmodule
